nco_sin_gen: RTL and testbench

- Parametrised successor to the single-tone sine generator: a multi-voice numerically controlled oscillator (NCO) running on sysClk, framed by the audio sample clock.
- On each audioClk rising edge it advances NUM_VOICES phase accumulators and looks up a quarter-wave sine table, time-multiplexed over the voices.
- It scales each voice by a per-voice amplitude, sums the voices with saturation and presents one signed sample to the audio output path.
- Replaces the fixed-step, CORDIC-based tone source with a programmable frequency, amplitude and voice count.

---
 rtl/nco_sin_gen_pkg.sv | 28 ++
 rtl/sin_quarter_lut.sv | 34 +++
 rtl/nco_sin_gen.sv | 162 ++++++++++++++++
 tb/tb_nco_sin_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_sin_gen_pkg.sv
// Shared types and width helpers for the multi-voice NCO sine generator.
package nco_sin_gen_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, MAC, DONE} ncoState_t;

  // Quadrants of one sine period, named by the shape of the curve within them
  typedef enum logic [1:0] {
    Q_RISE     = 2'd0,
    Q_FALL     = 2'd1,
    Q_NEG_FALL = 2'd2,
    Q_NEG_RISE = 2'd3
  } quadrant_t;

  function automatic int accWidth(input int dataW, input int ampW, input int numVoices);
    return dataW + ampW + $clog2(numVoices) + 1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int dataW);
    logic signed [63:0] maxVal;
    logic signed [63:0] minVal;
    maxVal = (64'sd1 <<< (dataW - 1)) - 64'sd1;
    minVal = -(64'sd1 <<< (dataW - 1));
    if (value > maxVal) return maxVal;
    if (value < minVal) return minVal;
    return value;
  endfunction

endpackage

// File: rtl/sin_quarter_lut.sv
// Quarter-wave sine ROM with a one-cycle registered read; contents computed at elaboration.
module sin_quarter_lut
  import nco_sin_gen_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LUT_ADDR_W = 8
) (
  input  logic                  sysClk,
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [DATA_W-2:0]     data
);

  localparam int DEPTH = 2 ** LUT_ADDR_W;

  // Half-step sample offset keeps the table symmetric so mirroring with ~idx is exact
  function automatic logic [DATA_W-2:0] sinEntry(input int i);
    real angle;
    real scaled;
    angle  = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(DEPTH);
    scaled = real'((2 ** (DATA_W - 1)) - 1) * $sin(angle);
    return (DATA_W-1)'($rtoi(scaled + 0.5));
  endfunction

  logic [DATA_W-2:0] romTable [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : genRom
    assign romTable[i] = sinEntry(i);
  end

  always_ff @(posedge sysClk) begin
    data <= romTable[addr];
  end

endmodule

// File: rtl/nco_sin_gen.sv
// Multi-voice NCO: per audio frame, walks the voices through a shared sine ROM,
// scales each by its amplitude and emits one saturated mixed sample.
module nco_sin_gen
  import nco_sin_gen_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24,
  parameter int DATA_W     = 16,
  parameter int AMP_W      = 8,
  parameter int LUT_ADDR_W = 8,
  localparam int ADDR_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                     sysClk,
  input  logic                     reset,
  input  logic                     audioClk,
  input  logic                     cfgWe,
  input  logic [ADDR_W-1:0]        cfgAddr,
  input  logic [PHASE_W-1:0]       cfgInc,
  input  logic [AMP_W-1:0]         cfgAmp,
  input  logic                     cfgPhaseClr,
  output logic signed [DATA_W-1:0] audioData,
  output logic                     audioValid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int ACC_W  = accWidth(DATA_W, AMP_W, NUM_VOICES);
  localparam int PROD_W = DATA_W + AMP_W + 1;

  logic sync1, sync2, prevSync, edgePulse;

  logic [PHASE_W-1:0] phase     [NUM_VOICES];
  logic [PHASE_W-1:0] shadowInc [NUM_VOICES];
  logic [PHASE_W-1:0] activeInc [NUM_VOICES];
  logic [AMP_W-1:0]   shadowAmp [NUM_VOICES];
  logic [AMP_W-1:0]   activeAmp [NUM_VOICES];
  logic [NUM_VOICES-1:0] clrPending;

  ncoState_t                state;
  logic [ADDR_W-1:0]        voice;
  logic signed [ACC_W-1:0]  acc;
  logic [LUT_ADDR_W-1:0]    lutAddr;
  logic                     negSin;
  logic [DATA_W-2:0]        lutData;

  quadrant_t                quadrant;
  logic [LUT_ADDR_W-1:0]    nextLutAddr;
  logic                     nextNeg;
  logic signed [DATA_W-1:0] signedSin;
  logic signed [PROD_W-1:0] product;
  logic signed [DATA_W-1:0] satData;
  logic                     cfgInRange;

  sin_quarter_lut #(
    .DATA_W    (DATA_W),
    .LUT_ADDR_W(LUT_ADDR_W)
  ) uLut (
    .sysClk(sysClk),
    .addr  (lutAddr),
    .data  (lutData)
  );

  // audioClk is foreign to sysClk, so it is treated as data and edge-detected after a 2-FF synchroniser
  always_ff @(posedge sysClk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prevSync <= 1'b0;
    end else begin
      sync1    <= audioClk;
      sync2    <= sync1;
      prevSync <= sync2;
    end
  end

  assign edgePulse  = sync2 & ~prevSync;
  assign cfgInRange = (int'(cfgAddr) < NUM_VOICES);

  always_comb begin
    quadrant    = quadrant_t'(phase[voice][PHASE_W-1 -: 2]);
    nextLutAddr = phase[voice][PHASE_W-3 -: LUT_ADDR_W];
    if (quadrant == Q_FALL || quadrant == Q_NEG_RISE) nextLutAddr = ~nextLutAddr;
    nextNeg   = (quadrant == Q_NEG_FALL) || (quadrant == Q_NEG_RISE);
    signedSin = negSin ? -$signed({1'b0, lutData}) : $signed({1'b0, lutData});
    product   = PROD_W'(signedSin) * PROD_W'($signed({1'b0, activeAmp[voice]}));
    satData   = DATA_W'(saturate(64'(acc >>> AMP_W), DATA_W));
  end

  // Frame sequencer: ADDR -> WAIT -> MAC per voice; config writes only ever touch the shadow copy
  always_ff @(posedge sysClk) begin
    if (reset) begin
      state      <= IDLE;
      voice      <= '0;
      acc        <= '0;
      lutAddr    <= '0;
      negSin     <= 1'b0;
      audioData  <= '0;
      audioValid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      clrPending <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i]     <= '0;
        shadowInc[i] <= '0;
        activeInc[i] <= '0;
        shadowAmp[i] <= '0;
        activeAmp[i] <= '0;
      end
    end else begin
      audioValid <= 1'b0;
      if (edgePulse && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (edgePulse) begin
            acc   <= '0;
            voice <= '0;
            busy  <= 1'b1;
            state <= ADDR;
            for (int i = 0; i < NUM_VOICES; i++) begin
              activeInc[i] <= shadowInc[i];
              activeAmp[i] <= shadowAmp[i];
              if (clrPending[i]) phase[i] <= '0;
            end
            clrPending <= '0;
          end
        end
        ADDR: begin
          lutAddr <= nextLutAddr;
          negSin  <= nextNeg;
          state   <= WAIT;
        end
        WAIT: state <= MAC;
        MAC: begin
          acc          <= acc + ACC_W'(product);
          phase[voice] <= phase[voice] + activeInc[voice];
          if (voice == ADDR_W'(NUM_VOICES - 1)) begin
            state <= DONE;
          end else begin
            voice <= voice + 1'b1;
            state <= ADDR;
          end
        end
        DONE: begin
          audioData  <= satData;
          audioValid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Placed after the frame-start clear so a same-cycle clear request stays pending
      if (cfgWe && cfgInRange) begin
        shadowInc[cfgAddr] <= cfgInc;
        shadowAmp[cfgAddr] <= cfgAmp;
        if (cfgPhaseClr) clrPending[cfgAddr] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nco_sin_gen.sv
// Scoreboard bench for nco_sin_gen: a behavioural model queues each frame's expected sample
// when the audio edge is driven, and a monitor pops and compares on every audioValid pulse.
module tb_nco_sin_gen;

  localparam int NV = 4;
  localparam int PW = 24;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LW = 8;

  logic          sysClk = 1'b0;
  logic          reset = 1'b1;
  logic          audioClk = 1'b0;
  logic          cfgWe = 1'b0;
  logic [1:0]    cfgAddr = '0;
  logic [PW-1:0] cfgInc = '0;
  logic [AW-1:0] cfgAmp = '0;
  logic          cfgPhaseClr = 1'b0;
  logic signed [DW-1:0] audioData;
  logic          audioValid, busy, overrun;

  int vectors = 0;
  int miscompares = 0;
  int expQ[$];

  logic [PW-1:0] mPhase [NV];
  logic [PW-1:0] mShInc [NV];
  logic [PW-1:0] mInc   [NV];
  int            mShAmp [NV];
  int            mAmp   [NV];
  bit            mClr   [NV];

  nco_sin_gen dut (
    .sysClk     (sysClk),
    .reset      (reset),
    .audioClk   (audioClk),
    .cfgWe      (cfgWe),
    .cfgAddr    (cfgAddr),
    .cfgInc     (cfgInc),
    .cfgAmp     (cfgAmp),
    .cfgPhaseClr(cfgPhaseClr),
    .audioData  (audioData),
    .audioValid (audioValid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 sysClk = ~sysClk;

  // Monitor: every audioValid pulse must match the oldest outstanding expectation
  always @(negedge sysClk) begin : monitor
    int e;
    if (audioValid === 1'b1) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpectedValid: audioData=%0d, required no pulse", audioData);
      end else begin
        e = expQ.pop_front();
        if (int'(audioData) !== e) begin
          miscompares++;
          $display("[TB] FAIL scoreboard: audioData=%0d, required %0d", audioData, e);
        end
      end
    end
  end

  function automatic int lutVal(input int k);
    real x;
    x = 32767.0 * $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic int sinOf(input logic [PW-1:0] ph);
    int q;
    int idx;
    q   = int'(ph[PW-1 -: 2]);
    idx = int'(ph[PW-3 -: LW]);
    if (q == 1 || q == 3) idx = 255 - idx;
    return (q >= 2) ? -lutVal(idx) : lutVal(idx);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NV; i++) begin
      mPhase[i] = '0; mShInc[i] = '0; mInc[i] = '0;
      mShAmp[i] = 0;  mAmp[i] = 0;    mClr[i] = 1'b0;
    end
  endtask

  task automatic modelFrame(output int result);
    longint acc;
    longint s;
    acc = 0;
    for (int i = 0; i < NV; i++) begin
      mInc[i] = mShInc[i];
      mAmp[i] = mShAmp[i];
      if (mClr[i]) begin
        mPhase[i] = '0;
        mClr[i] = 1'b0;
      end
    end
    for (int i = 0; i < NV; i++) begin
      acc = acc + longint'(sinOf(mPhase[i])) * longint'(mAmp[i]);
      mPhase[i] = mPhase[i] + mInc[i];
    end
    s = acc >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    result = int'(s);
  endtask

  task automatic cfgWrite(input int v, input logic [PW-1:0] inc, input int amp, input bit clr);
    @(negedge sysClk);
    cfgWe = 1'b1; cfgAddr = v[1:0]; cfgInc = inc; cfgAmp = amp[7:0]; cfgPhaseClr = clr;
    if (v < NV) begin
      mShInc[v] = inc;
      mShAmp[v] = amp;
      if (clr) mClr[v] = 1'b1;
    end
    @(negedge sysClk);
    cfgWe = 1'b0; cfgPhaseClr = 1'b0;
  endtask

  // Raises audioClk for three cycles; the expected frame is queued at the edge
  task automatic applyStimulus(input bit expectFrame);
    int e;
    @(negedge sysClk);
    audioClk = 1'b1;
    if (expectFrame) begin
      modelFrame(e);
      expQ.push_back(e);
    end
    repeat (3) @(negedge sysClk);
    audioClk = 1'b0;
  endtask

  task automatic waitIdle();
    repeat (20) @(negedge sysClk);
  endtask

  task automatic test_reset();
    int e;
    int tones[3];
    tones = '{32639, -101, -32640};
    reset = 1'b1;
    repeat (3) @(negedge sysClk);
    vectors += 4;
    if (audioData !== 16'sd0) begin miscompares++; $display("[TB] FAIL resetData: got %0d, expected 0", audioData); end
    if (audioValid !== 1'b0) begin miscompares++; $display("[TB] FAIL resetValid: got %b, expected 0", audioValid); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL resetBusy: got %b, expected 0", busy); end
    if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL resetOverrun: got %b, expected 0", overrun); end
    reset = 1'b0;
    modelReset();
    cfgWrite(0, 24'h400000, 255, 1'b0);

    // First sysClk edge seeing audioClk high is S; the sample must appear in cycle S+16
    @(negedge sysClk);
    audioClk = 1'b1;
    modelFrame(e);
    expQ.push_back(e);
    @(posedge sysClk);
    repeat (14) @(posedge sysClk);
    #1;
    vectors++;
    if (audioValid !== 1'b0) begin miscompares++; $display("[TB] FAIL validEarly: got %b, expected 0", audioValid); end
    @(posedge sysClk);
    #1;
    vectors += 2;
    if (audioValid !== 1'b1) begin miscompares++; $display("[TB] FAIL validAtS16: got %b, expected 1", audioValid); end
    if (audioData !== 16'sd100) begin miscompares++; $display("[TB] FAIL firstSample: got %0d, expected 100", audioData); end
    @(posedge sysClk);
    #1;
    vectors++;
    if (audioValid !== 1'b0) begin miscompares++; $display("[TB] FAIL validWidth: got %b, expected 0", audioValid); end
    audioClk = 1'b0;
    waitIdle();

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1);
      waitIdle();
      vectors++;
      if (int'(audioData) !== tones[k]) begin
        miscompares++;
        $display("[TB] FAIL toneSeq%0d: got %0d, expected %0d", k, audioData, tones[k]);
      end
    end
    applyStimulus(1'b1);
    waitIdle();
  endtask

  task automatic test_saturation();
    int satExp[4];
    satExp = '{402, 32767, -403, -32768};
    for (int v = 0; v < NV; v++) cfgWrite(v, 24'h400000, 255, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1);
      waitIdle();
      vectors++;
      if (int'(audioData) !== satExp[k]) begin
        miscompares++;
        $display("[TB] FAIL satFrame%0d: got %0d, expected %0d", k, audioData, satExp[k]);
      end
    end
  endtask

  task automatic test_shadow();
    for (int v = 1; v < NV; v++) cfgWrite(v, 24'h400000, 0, 1'b1);
    cfgWrite(0, 24'h400000, 255, 1'b1);
    applyStimulus(1'b1);
    repeat (5) @(negedge sysClk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL shadowBusy: got %b, expected 1", busy); end
    cfgWrite(0, 24'h400000, 0, 1'b0);
    waitIdle();
    vectors++;
    if (audioData !== 16'sd100) begin miscompares++; $display("[TB] FAIL shadowHold: got %0d, expected 100", audioData); end
    applyStimulus(1'b1);
    waitIdle();
    vectors++;
    if (audioData !== 16'sd0) begin miscompares++; $display("[TB] FAIL shadowApply: got %0d, expected 0", audioData); end
  endtask

  task automatic test_phase_clear();
    cfgWrite(0, 24'h400000, 255, 1'b1);
    applyStimulus(1'b1);
    waitIdle();
    vectors++;
    if (audioData !== 16'sd100) begin miscompares++; $display("[TB] FAIL phaseClear: got %0d, expected 100", audioData); end
  endtask

  task automatic test_overrun();
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL overrunBefore: got %b, expected 0", overrun); end
    applyStimulus(1'b1);
    repeat (3) @(negedge sysClk);
    audioClk = 1'b1;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL overrunBusy: got %b, expected 1", busy); end
    repeat (3) @(negedge sysClk);
    audioClk = 1'b0;
    waitIdle();
    vectors += 2;
    if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrunSet: got %b, expected 1", overrun); end
    if (audioData !== 16'sd32639) begin miscompares++; $display("[TB] FAIL overrunData: got %0d, expected 32639", audioData); end
    applyStimulus(1'b1);
    waitIdle();
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrunSticky: got %b, expected 1", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge sysClk);
    audioClk = 1'b1;
    repeat (3) @(negedge sysClk);
    audioClk = 1'b0;
    @(negedge sysClk);
    reset = 1'b1;
    @(negedge sysClk);
    vectors += 4;
    if (audioData !== 16'sd0) begin miscompares++; $display("[TB] FAIL midResetData: got %0d, expected 0", audioData); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midResetBusy: got %b, expected 0", busy); end
    if (audioValid !== 1'b0) begin miscompares++; $display("[TB] FAIL midResetValid: got %b, expected 0", audioValid); end
    if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL midResetOverrun: got %b, expected 0", overrun); end
    reset = 1'b0;
    modelReset();
    waitIdle();
    cfgWrite(0, 24'h400000, 255, 1'b0);
    applyStimulus(1'b1);
    waitIdle();
    vectors++;
    if (audioData !== 16'sd100) begin miscompares++; $display("[TB] FAIL postResetPhase: got %0d, expected 100", audioData); end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_saturation();
    test_shadow();
    test_phase_clear();
    test_overrun();
    test_reset_mid_frame();
    repeat (5) @(negedge sysClk);
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL missingSamples: %0d outstanding, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
